// File: rtl/wfi_ctrl_pkg.sv
// Shared types for the WFI controller: FSM state encoding and privilege-mode codes.
package wfi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    TRAP = 2'b10,
    WAKE = 2'b11
  } wfi_state_t;

  localparam logic [1:0] M_MODE = 2'b11;
  localparam logic [1:0] S_MODE = 2'b01;
  localparam logic [1:0] U_MODE = 2'b00;

endpackage

// File: rtl/wfi_ctrl_timer.sv
// WFI timeout timer: saturating cycle counter, latched limit and an equality compare.
module wfi_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limit_q;

  // Counter sticks at all-ones so a maximal limit still matches exactly once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      limit_q <= '0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (inc && (count != '1)) begin
        count <= count + CNT_W'(1);
      end
      if (load) begin
        limit_q <= limit;
      end
    end
  end

  assign expired = (count == limit_q);

endmodule

// File: rtl/wfi_ctrl.sv
// WFI controller: holds a committed WFI in M until interrupt wake, timeout fault or flush.
module wfi_ctrl
  import wfi_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned NUM_IRQ     = 12,
  parameter bit          S_SUPPORTED = 1'b1,
  parameter bit          U_SUPPORTED = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               StallW,
  input  logic               FlushW,
  input  logic               FlushM,
  input  logic               wfiM,
  input  logic [1:0]         PrivilegeModeW,
  input  logic               STATUS_TW,
  input  logic [NUM_IRQ-1:0] MIP,
  input  logic [NUM_IRQ-1:0] MIE,
  input  logic [CNT_W-1:0]   WFILimit,
  output logic               WFIStallM,
  output logic               WFITimeoutM,
  output logic               WFIWakeM,
  output logic               wfiW,
  output logic               WFIBusy
);

  wfi_state_t state, state_n;
  logic       wake;
  logic       armed;
  logic       expired;
  logic       timer_clear, timer_load, timer_inc;

  // Wake ignores global MIE/SIE: any individually enabled pending interrupt ends the WFI.
  assign wake  = |(MIP & MIE);
  assign armed = U_SUPPORTED &&
                 ((STATUS_TW && (PrivilegeModeW != M_MODE)) ||
                  (S_SUPPORTED && (PrivilegeModeW == U_MODE)));

  if (U_SUPPORTED) begin : g_timer
    wfi_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .load    (timer_load),
      .inc     (timer_inc),
      .limit   (WFILimit),
      .expired (expired)
    );
  end else begin : g_no_timer
    assign expired = 1'b0;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next state and timer control; flush beats wake beats timeout in WAIT
  always_comb begin
    state_n     = state;
    timer_clear = 1'b0;
    timer_load  = 1'b0;
    timer_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (wfiM && !FlushM) begin
          if (wake) begin
            state_n = WAKE;
          end else begin
            state_n     = WAIT;
            timer_clear = 1'b1;
            timer_load  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (FlushM) begin
          state_n     = IDLE;
          timer_clear = 1'b1;
        end else if (wake) begin
          state_n = WAKE;
        end else if (armed && expired) begin
          state_n = TRAP;
        end else begin
          timer_inc = 1'b1;
        end
      end
      TRAP:    state_n = IDLE;
      WAKE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so they are glitch-free and exclusive
  always_comb begin
    WFIStallM   = (state == WAIT);
    WFITimeoutM = (state == TRAP);
    WFIWakeM    = (state == WAKE);
    WFIBusy     = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     wfiW <= 1'b0;
    else if (FlushW)  wfiW <= 1'b0;
    else if (!StallW) wfiW <= wfiM && ((state == WAKE) || ((state == IDLE) && wake));
  end

endmodule

// File: tb/tb_wfi_ctrl.sv
// Bench for wfi_ctrl: directed scenarios plus random traffic checked against a cycle-count model.
module tb_wfi_ctrl;

  localparam int unsigned CW   = 4;
  localparam int unsigned NI   = 12;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk, reset_n;
  logic          StallW, FlushW, FlushM, wfiM, STATUS_TW;
  logic [1:0]    PrivilegeModeW;
  logic [NI-1:0] MIP, MIE;
  logic [CW-1:0] WFILimit;
  logic          WFIStallM, WFITimeoutM, WFIWakeM, wfiW, WFIBusy;

  wfi_ctrl #(.CNT_W(CW), .NUM_IRQ(NI), .S_SUPPORTED(1'b1), .U_SUPPORTED(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .StallW(StallW), .FlushW(FlushW), .FlushM(FlushM),
    .wfiM(wfiM), .PrivilegeModeW(PrivilegeModeW), .STATUS_TW(STATUS_TW), .MIP(MIP), .MIE(MIE),
    .WFILimit(WFILimit), .WFIStallM(WFIStallM), .WFITimeoutM(WFITimeoutM), .WFIWakeM(WFIWakeM),
    .wfiW(wfiW), .WFIBusy(WFIBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int faults = 0;
  int wakes  = 0;

  // Reference: "waiting" plus elapsed cycles since acceptance; pulses are separate flags.
  bit m_waiting, m_fault, m_woke, m_wfiw;
  int m_elapsed, m_lim;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("stall",   WFIStallM,   m_waiting);
    check("timeout", WFITimeoutM, m_fault);
    check("wake",    WFIWakeM,    m_woke);
    check("busy",    WFIBusy,     m_waiting | m_fault | m_woke);
    check("wfiW",    wfiW,        m_wfiw);
  endtask

  task automatic model_reset();
    m_waiting = 0; m_fault = 0; m_woke = 0; m_wfiw = 0; m_elapsed = 0; m_lim = 0;
  endtask

  // Predict next cycle from current inputs, clock once, then compare.
  task automatic tick();
    bit wk, arm, idle, n_wait, n_fault, n_woke, n_wfiw;
    int cnt, n_el, n_lim;
    wk   = |(MIP & MIE);
    arm  = (STATUS_TW && PrivilegeModeW != 2'b11) || (PrivilegeModeW == 2'b00);
    idle = !m_waiting && !m_fault && !m_woke;
    cnt  = (m_elapsed > MAXC) ? MAXC : m_elapsed;
    n_wait = 0; n_fault = 0; n_woke = 0; n_el = m_elapsed; n_lim = m_lim;
    if (idle) begin
      if (wfiM && !FlushM) begin
        if (wk) n_woke = 1;
        else begin n_wait = 1; n_el = 0; n_lim = int'(WFILimit); end
      end
    end else if (m_waiting) begin
      if (FlushM)                  n_el = 0;
      else if (wk)                 n_woke = 1;
      else if (arm && cnt == m_lim) n_fault = 1;
      else begin n_wait = 1; n_el = m_elapsed + 1; end
    end
    if (FlushW)       n_wfiw = 0;
    else if (!StallW) n_wfiw = wfiM && (m_woke || (idle && wk));
    else              n_wfiw = m_wfiw;
    @(posedge clk);
    #1;
    m_waiting = n_wait; m_fault = n_fault; m_woke = n_woke;
    m_elapsed = n_el; m_lim = n_lim; m_wfiw = n_wfiw;
    if (WFITimeoutM) faults++;
    if (WFIWakeM) wakes++;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int f0, w0;
    reset_n = 0; StallW = 0; FlushW = 0; FlushM = 0; wfiM = 0; STATUS_TW = 0;
    PrivilegeModeW = 2'b00; MIP = '0; MIE = '0; WFILimit = '0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk) reset_n = 1;
    ticks(2);

    // 1: U mode, TW=0, limit 5 -> single timeout fault
    WFILimit = 4'd5; wfiM = 1; f0 = faults;
    tick();
    wfiM = 0;
    ticks(10);
    check_int("t1_faults", faults - f0, 1);

    // 2: M mode, TW=1 is unarmed; enabled interrupt after a long wait wakes it
    PrivilegeModeW = 2'b11; STATUS_TW = 1; WFILimit = 4'd3; wfiM = 1; f0 = faults;
    ticks(30);
    MIP[7] = 1; MIE[7] = 1;
    tick();
    check("t2_wake", WFIWakeM, 1'b1);
    tick();
    check("t2_wfiW", wfiW, 1'b1);
    wfiM = 0; MIP = '0; MIE = '0;
    ticks(3);
    check_int("t2_faults", faults - f0, 0);

    // 3: S mode armed; wake in the same cycle count hits limit wins
    PrivilegeModeW = 2'b01; STATUS_TW = 1; WFILimit = 4'd4; wfiM = 1; f0 = faults;
    ticks(5);
    MIP[3] = 1; MIE[3] = 1;
    tick();
    check("t3_wake", WFIWakeM, 1'b1);
    wfiM = 0; MIP = '0; MIE = '0;
    ticks(3);
    check_int("t3_faults", faults - f0, 0);

    // 4: wake already pending -> no stall; then MIE=0 blocks wake
    MIP[5] = 1; MIE[5] = 1; wfiM = 1;
    tick();
    wfiM = 0;
    tick();
    MIE = '0; MIP = '1; PrivilegeModeW = 2'b11; STATUS_TW = 0; wfiM = 1;
    tick();
    wfiM = 0;
    ticks(20);
    check("t4_waiting", WFIStallM, 1'b1);
    FlushM = 1; tick(); FlushM = 0; MIP = '0;
    ticks(2);

    // 5: flush at count=2, then a fresh WFI restarts the count
    PrivilegeModeW = 2'b00; WFILimit = 4'd10; wfiM = 1; f0 = faults; w0 = wakes;
    tick(); wfiM = 0;
    ticks(2);
    FlushM = 1; tick(); FlushM = 0;
    check("t5_idle", WFIBusy, 1'b0);
    wfiM = 1; tick(); wfiM = 0;
    ticks(9);
    check_int("t5_early", faults - f0, 0);
    ticks(4);
    check_int("t5_faults", faults - f0, 1);
    check_int("t5_wakes", wakes - w0, 0);

    // 6: async reset mid-wait, then maximal limit saturates and faults once
    WFILimit = 4'd12; wfiM = 1;
    tick(); wfiM = 0;
    ticks(9);
    #2 reset_n = 0;
    #1 model_reset();
    check_outputs();
    @(negedge clk) reset_n = 1;
    WFILimit = 4'd15; wfiM = 1; f0 = faults;
    tick(); wfiM = 0;
    ticks(15);
    check_int("t6_early", faults - f0, 0);
    ticks(10);
    check_int("t6_faults", faults - f0, 1);

    // Random traffic; wake kept rare by sparse enables
    for (int i = 0; i < 800; i++) begin
      wfiM      = ($urandom_range(0, 2) == 0);
      FlushM    = ($urandom_range(0, 15) == 0);
      StallW    = ($urandom_range(0, 3) == 0);
      FlushW    = ($urandom_range(0, 7) == 0);
      STATUS_TW = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0:       PrivilegeModeW = 2'b00;
        1:       PrivilegeModeW = 2'b01;
        default: PrivilegeModeW = 2'b11;
      endcase
      WFILimit = CW'($urandom_range(0, 15));
      MIP = NI'($urandom);
      MIE = ($urandom_range(0, 9) == 0) ? NI'($urandom) : '0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench time limit");
  end

endmodule
